// File: rtl/fir_pkg.sv
// Shared widths, defaults and helpers for the FIR output requantiser.
package fir_pkg;

    localparam int N2_DEF    = 18;   // FIR product width (upstream)
    localparam int N3_DEF    = 32;   // accumulator width
    localparam int NO_DEF    = 16;   // output sample width
    localparam int SHIFT_DEF = 7;    // right shift after rounding
    localparam int DEPTH_DEF = 4;    // output FIFO depth

    // 16-bit event counter that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/fir_fwft_fifo.sv
// First-word-fall-through FIFO: the head word is visible on rdata whenever
// empty is low, and pop advances it at the next edge.
module fir_fwft_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             level_q, level_d;
    logic                    pop_ok, push_ok;

    // Status comes straight from the level register.
    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is reset too so the head reads zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: round-and-shift, clamp to NO bits, then buffer in a
// small FWFT FIFO. Upstream cannot be stalled, so words arriving at a full
// FIFO are dropped and counted.
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int N3    = N3_DEF,
    parameter int NO    = NO_DEF,
    parameter int SHIFT = SHIFT_DEF,   // 1 .. N3-NO
    parameter int DEPTH = DEPTH_DEF    // power of two, >= 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [N3-1:0]             din,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NO-1:0]             dout,
    output logic [$clog2(DEPTH):0]    level,
    output logic [15:0]               sat_cnt,
    output logic [15:0]               ovf_cnt
);

    // Clamp bounds expressed in the widened stage-1 width.
    localparam logic signed [N3:0] MAXV = {{(N3-NO+2){1'b0}}, {(NO-1){1'b1}}};
    localparam logic signed [N3:0] MINV = ~MAXV;
    localparam logic signed [N3:0] HALF = (N3+1)'(1) << (SHIFT-1);

    // vld_pipe_q[0] tags stage 1, vld_pipe_q[1] tags stage 2.
    logic [1:0]         vld_pipe_q, vld_pipe_d;
    logic signed [N3:0] rnd_q, rnd_d;
    logic [NO-1:0]      clp_q, clp_d;
    logic               sat_q, sat_d;
    logic [15:0]        sat_cnt_q, sat_cnt_d;
    logic [15:0]        ovf_cnt_q, ovf_cnt_d;

    logic signed [N3:0] din_ext;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop, drop;

    assign din_ext = {din[N3-1], din};

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = vld_pipe_q[1] && (!fifo_full || fifo_pop);
    assign drop      = vld_pipe_q[1] && fifo_full && !fifo_pop;

    assign sat_cnt = sat_cnt_q;
    assign ovf_cnt = ovf_cnt_q;

    // Pipeline next-state: round (ties to +inf) in N3+1 bits, then clamp.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], in_valid};
        rnd_d      = (din_ext + HALF) >>> SHIFT;
        sat_d      = 1'b0;
        clp_d      = rnd_q[NO-1:0];
        if (rnd_q > MAXV) begin
            clp_d = MAXV[NO-1:0];
            sat_d = 1'b1;
        end else if (rnd_q < MINV) begin
            clp_d = MINV[NO-1:0];
            sat_d = 1'b1;
        end
    end

    // Event counters; a saturated word counts even when it is then dropped.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (vld_pipe_q[1] && sat_q) sat_cnt_d = sat_inc16(sat_cnt_q);
        if (drop)                   ovf_cnt_d = sat_inc16(ovf_cnt_q);
    end

    // Free-running pipeline and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            rnd_q      <= '0;
            clp_q      <= '0;
            sat_q      <= 1'b0;
            sat_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            rnd_q      <= rnd_d;
            clp_q      <= clp_d;
            sat_q      <= sat_d;
            sat_cnt_q  <= sat_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    fir_fwft_fifo #(
        .W     (NO),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (clp_q),
        .pop   (fifo_pop),
        .rdata (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule
